// File: rtl/alu_exec_unit_if.sv
// Handshake and data bundle between the pipeline and alu_exec_unit.
//   valid_i   : op request (accepted when valid_i && ready_o at a rising edge)
//   ALUCtrl_i : 4-bit ALU control code
//   src1_i    : operand A (multiplicand for MUL)
//   src2_i    : operand B (multiplier for MUL)
//   ready_o   : unit can accept a request this cycle
//   valid_o   : one-cycle pulse, result_o/zero_o/illegal_o are valid
//   result_o  : registered result, held until the next completion
//   zero_o    : registered, result_o == 0
//   illegal_o : registered, completed op had an undefined code
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             illegal_o;

    modport master (
        output valid_i, ALUCtrl_i, src1_i, src2_i,
        input  ready_o, valid_o, result_o, zero_o, illegal_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, src1_i, src2_i,
        output ready_o, valid_o, result_o, zero_o, illegal_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. AND/OR/ADD/SUB/SLT and undefined codes complete in one
// cycle; MUL runs on an iterative shift-add multiplier taking WIDTH cycles,
// during which ready_o is low and new requests are ignored.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-low reset
//   bus   : alu_exec_unit_if slave port (request, handshake, result)
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input logic         clk_i,
    input logic         rst_i,
    alu_exec_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_MUL = 4'b1000
    } op_t;

    state_t           state;
    state_t           state_next;
    op_t              op;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] op_res;
    logic             op_ill;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_step;
    logic             mul_last;

    assign op       = op_t'(bus.ALUCtrl_i);
    assign accept   = bus.valid_i && (state == S_IDLE);
    assign is_mul   = (op == OP_MUL);
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));

    // Single-cycle datapath; undefined codes yield zero with illegal flagged.
    always_comb begin
        op_res = '0;
        op_ill = 1'b0;
        case (op)
            OP_AND:  op_res = bus.src1_i & bus.src2_i;
            OP_OR:   op_res = bus.src1_i | bus.src2_i;
            OP_ADD:  op_res = bus.src1_i + bus.src2_i;
            OP_SUB:  op_res = bus.src1_i - bus.src2_i;
            OP_SLT:  op_res = ($signed(bus.src1_i) < $signed(bus.src2_i))
                              ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            OP_MUL:  op_res = '0;
            default: op_ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_next = S_MUL;
            S_MUL:   if (mul_last)         state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ready_o = (state == S_IDLE);
    end

    // Result registers and multiplier datapath
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bus.valid_o   <= 1'b0;
            bus.result_o  <= '0;
            bus.zero_o    <= 1'b1;
            bus.illegal_o <= 1'b0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            cnt           <= '0;
        end else begin
            bus.valid_o <= 1'b0;
            if (accept) begin
                if (is_mul) begin
                    mcand  <= bus.src1_i;
                    mplier <= bus.src2_i;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    bus.valid_o   <= 1'b1;
                    bus.result_o  <= op_res;
                    bus.zero_o    <= (op_res == '0);
                    bus.illegal_o <= op_ill;
                end
            end else if (state == S_MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                // Counter is not advanced on the final iteration so it never reaches WIDTH.
                if (mul_last) begin
                    bus.valid_o   <= 1'b1;
                    bus.result_o  <= acc_step;
                    bus.zero_o    <= (acc_step == '0);
                    bus.illegal_o <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH = 32).
module tb_alu_exec_unit;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] code,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bus.valid_i   = v;
        bus.ALUCtrl_i = code;
        bus.src1_i    = a;
        bus.src2_i    = b;
    endtask

    // Issue a MUL, return result and number of edges after acceptance until valid_o.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output int lat, output int busy);
        drive(1'b1, 4'b1000, a, b);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        lat  = 0;
        busy = 0;
        res  = 'x;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o === 1'b0) busy++;
            step();
            lat++;
            if (bus.valid_o === 1'b1) begin
                res = bus.result_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 4'b0010, 32'd1, 32'd1);
        rst = 1'b0;
        step();
        step();
        checks++; if (bus.ready_o !== 1'b1)   begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
        checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
        checks++; if (bus.zero_o !== 1'b1)    begin errors++; $display("FAIL reset_zero got=%b exp=1", bus.zero_o); end
        checks++; if (bus.illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal_o); end
        drive(1'b0, 4'b0000, '0, '0);
        rst = 1'b1;
        step();
    endtask

    task automatic test_add();
        drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        checks++; if (bus.valid_o !== 1'b1)          begin errors++; $display("FAIL add_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.result_o !== 32'h8000_0000) begin errors++; $display("FAIL add_result got=%h exp=80000000", bus.result_o); end
        checks++; if (bus.zero_o !== 1'b0)           begin errors++; $display("FAIL add_zero got=%b exp=0", bus.zero_o); end
        checks++; if (bus.illegal_o !== 1'b0)        begin errors++; $display("FAIL add_illegal got=%b exp=0", bus.illegal_o); end
        step();
        checks++; if (bus.valid_o !== 1'b0)          begin errors++; $display("FAIL add_pulse got=%b exp=0", bus.valid_o); end
        checks++; if (bus.result_o !== 32'h8000_0000) begin errors++; $display("FAIL add_hold got=%h exp=80000000", bus.result_o); end
    endtask

    task automatic test_logic();
        drive(1'b1, 4'b0000, 32'hF0F0_1234, 32'hFF00_00FF);
        step();
        checks++; if (bus.result_o !== 32'hF000_0034) begin errors++; $display("FAIL and_result got=%h exp=f0000034", bus.result_o); end
        drive(1'b1, 4'b0001, 32'hF0F0_1234, 32'h0F00_0001);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        checks++; if (bus.result_o !== 32'hFFF0_1235) begin errors++; $display("FAIL or_result got=%h exp=fff01235", bus.result_o); end
        step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'b0110, 32'd5, 32'd5);
        checks++; if (bus.ready_o !== 1'b1)   begin errors++; $display("FAIL b2b_ready0 got=%b exp=1", bus.ready_o); end
        step();
        checks++; if (bus.valid_o !== 1'b1)   begin errors++; $display("FAIL sub_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL sub_result got=%h exp=0", bus.result_o); end
        checks++; if (bus.zero_o !== 1'b1)    begin errors++; $display("FAIL sub_zero got=%b exp=1", bus.zero_o); end
        checks++; if (bus.ready_o !== 1'b1)   begin errors++; $display("FAIL b2b_ready1 got=%b exp=1", bus.ready_o); end
        drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        checks++; if (bus.valid_o !== 1'b1)   begin errors++; $display("FAIL slt_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.result_o !== 32'd1) begin errors++; $display("FAIL slt_result got=%h exp=1", bus.result_o); end
        checks++; if (bus.zero_o !== 1'b0)    begin errors++; $display("FAIL slt_zero got=%b exp=0", bus.zero_o); end
        checks++; if (bus.ready_o !== 1'b1)   begin errors++; $display("FAIL b2b_ready2 got=%b exp=1", bus.ready_o); end
        drive(1'b1, 4'b0111, 32'd1, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL slt_false got=%h exp=0", bus.result_o); end
        step();
    endtask

    task automatic test_mul();
        int busy;
        int lat;
        logic seen;
        // Accept at edge T; ready_o must be low after edges T..T+31, valid_o after T+32.
        drive(1'b1, 4'b1000, 32'h0000_FFFF, 32'h0001_0001);
        step();
        // Request raised while busy; it must be dropped.
        drive(1'b1, 4'b0010, 32'd1, 32'd1);
        busy = 0;
        lat  = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o === 1'b0) busy++;
            if (i == 3) drive(1'b0, 4'b0000, '0, '0);
            step();
            lat++;
            if (bus.valid_o === 1'b1) break;
        end
        checks++; if (lat != 32)                  begin errors++; $display("FAIL mul_latency got=%0d exp=32", lat); end
        checks++; if (busy != 32)                 begin errors++; $display("FAIL mul_busy got=%0d exp=32", busy); end
        checks++; if (bus.valid_o !== 1'b1)       begin errors++; $display("FAIL mul_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.result_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_result got=%h exp=ffffffff", bus.result_o); end
        checks++; if (bus.ready_o !== 1'b1)       begin errors++; $display("FAIL mul_ready_after got=%b exp=1", bus.ready_o); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.valid_o === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0)              begin errors++; $display("FAIL mul_dropped_req got=%b exp=0", seen); end
        checks++; if (bus.result_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_hold got=%h exp=ffffffff", bus.result_o); end
    endtask

    task automatic test_mul_signed();
        logic [W-1:0] res;
        int lat;
        int busy;
        run_mul(32'hFFFF_FFFD, 32'd7, res, lat, busy);
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_signed got=%h exp=ffffffeb", res); end
        checks++; if (bus.zero_o !== 1'b0)   begin errors++; $display("FAIL mul_signed_zero got=%b exp=0", bus.zero_o); end
        step();
        run_mul(32'd0, 32'h1234_5678, res, lat, busy);
        checks++; if (res !== 32'd0)         begin errors++; $display("FAIL mul_zero got=%h exp=0", res); end
        checks++; if (bus.zero_o !== 1'b1)   begin errors++; $display("FAIL mul_zero_flag got=%b exp=1", bus.zero_o); end
        checks++; if (lat != 32)             begin errors++; $display("FAIL mul_zero_latency got=%0d exp=32", lat); end
        step();
    endtask

    task automatic test_illegal();
        drive(1'b1, 4'b0010, 32'd20, 32'd22);
        step();
        drive(1'b1, 4'b1111, 32'h1234, 32'h5678);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        checks++; if (bus.valid_o !== 1'b1)   begin errors++; $display("FAIL ill_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.illegal_o !== 1'b1) begin errors++; $display("FAIL ill_flag got=%b exp=1", bus.illegal_o); end
        checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL ill_result got=%h exp=0", bus.result_o); end
        checks++; if (bus.zero_o !== 1'b1)    begin errors++; $display("FAIL ill_zero got=%b exp=1", bus.zero_o); end
        drive(1'b1, 4'b0010, 32'd1, 32'd1);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        checks++; if (bus.illegal_o !== 1'b0) begin errors++; $display("FAIL ill_clear got=%b exp=0", bus.illegal_o); end
        checks++; if (bus.result_o !== 32'd2) begin errors++; $display("FAIL ill_next_add got=%h exp=2", bus.result_o); end
        step();
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        drive(1'b1, 4'b1000, 32'd3, 32'd5);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        for (int i = 0; i < 10; i++) step();
        rst = 1'b0;
        step();
        checks++; if (bus.ready_o !== 1'b1)   begin errors++; $display("FAIL rmul_ready got=%b exp=1", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0)   begin errors++; $display("FAIL rmul_valid got=%b exp=0", bus.valid_o); end
        checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL rmul_result got=%h exp=0", bus.result_o); end
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.valid_o !== 1'b0) stray++;
        end
        checks++; if (stray != 0)             begin errors++; $display("FAIL rmul_stray got=%0d exp=0", stray); end
        drive(1'b1, 4'b0010, 32'd2, 32'd3);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        checks++; if (bus.valid_o !== 1'b1)   begin errors++; $display("FAIL rmul_add_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.result_o !== 32'd5) begin errors++; $display("FAIL rmul_add_result got=%h exp=5", bus.result_o); end
        step();
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 4'b0000, '0, '0);
        test_reset();
        test_add();
        test_logic();
        test_back_to_back();
        test_mul();
        test_mul_signed();
        test_illegal();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
